// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
//   Shared definitions for the result request path: request word width, the
//   bit positions of its three fields, the class code used for malformed
//   frames, the drop counter width, the issue FSM state type and a helper
//   that assembles a request word from its fields.
// -----------------------------------------------------------------------------
package result_pkg;

  localparam int REQ_W = 12;

  // Request word layout: frame id | class | confidence
  localparam int FID_HI  = 11;
  localparam int FID_LO  = 8;
  localparam int CLS_HI  = 7;
  localparam int CLS_LO  = 4;
  localparam int CONF_HI = 3;
  localparam int CONF_LO = 0;

  // Class code reported when a frame carried the wrong number of beats
  localparam logic [3:0] MALFORMED_CLASS = 4'hF;

  localparam int DROP_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } issue_state_e;

  function automatic logic [REQ_W-1:0] pack_req(input logic [3:0] fid,
                                                input logic [3:0] cls,
                                                input logic [3:0] conf);
    logic [REQ_W-1:0] req;
    req                  = '0;
    req[FID_HI:FID_LO]   = fid;
    req[CLS_HI:CLS_LO]   = cls;
    req[CONF_HI:CONF_LO] = conf;
    return req;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is visible on
//   rd_data whenever empty is low; rd_en consumes it on the next edge.
//   A write while full is accepted only when a read happens on the same edge.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   wr_en    in   push wr_data
//   wr_data  in   WIDTH-bit entry
//   rd_en    in   pop the head entry
//   rd_data  out  head entry (valid while !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   level    out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module result_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,   // power of two, >= 2
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still legal then.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, and leaving it out keeps the array in plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/result_request_packer.sv
// -----------------------------------------------------------------------------
// result_request_packer
//   Consumes a classifier score stream (one signed score per beat, frame ends
//   on score_last), finds the argmax class and a 4-bit confidence, packs them
//   with a rolling 4-bit frame id into a 12-bit request, queues the request
//   and issues queued requests as one-cycle Request_vld pulses spaced at
//   least GAP_CYCLES apart so the downstream serializer is never reloaded
//   while it is still shifting.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   score_data   in   signed class score
//   score_valid  in   beat valid
//   score_last   in   final beat of the frame
//   score_ready  out  always 1 outside reset; overflow is handled by dropping
//   Request      out  last issued request word (held between pulses)
//   Request_vld  out  one-cycle load strobe for Request
//   fifo_level   out  pending requests
//   drop_count   out  saturating count of frames lost to a full queue
// -----------------------------------------------------------------------------
module result_request_packer
  import result_pkg::*;
#(
  parameter  int N_CLASSES  = 10,   // 1..15
  parameter  int SCORE_W    = 16,   // >= 6
  parameter  int GAP_CYCLES = 402,  // >= 2
  parameter  int FIFO_DEPTH = 4,    // power of two
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_valid,
  input  logic                      score_last,
  output logic                      score_ready,
  output logic [REQ_W-1:0]          Request,
  output logic                      Request_vld,
  output logic [LVL_W-1:0]          fifo_level,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int TMR_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [4:0] BEAT_SAT = 5'd16;

  // ---------------------------------------------------------------------------
  // Accumulation / finalisation state
  // ---------------------------------------------------------------------------
  logic                      score_ready_q;
  logic [4:0]                beat_idx_q;
  logic signed [SCORE_W-1:0] best_q;
  logic [3:0]                best_idx_q;
  logic [3:0]                frame_id_q;
  logic                      fin_vld_q;
  logic [REQ_W-1:0]          fin_word_q;
  logic [DROP_W-1:0]         drop_cnt_q;

  logic                      beat_fire;
  logic signed [SCORE_W-1:0] best_d;
  logic [3:0]                best_idx_d;
  logic [4:0]                beat_idx_d;
  logic [5:0]                total_beats;
  logic                      malformed;
  logic [3:0]                conf;
  logic [3:0]                cls;
  logic [REQ_W-1:0]          fin_word_d;

  // ---------------------------------------------------------------------------
  // Issue FSM state
  // ---------------------------------------------------------------------------
  issue_state_e              state_q;
  logic [TMR_W-1:0]          timer_q;
  logic [REQ_W-1:0]          request_q;
  logic                      request_vld_q;

  // Queue interface
  logic                      fifo_wr;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [REQ_W-1:0]          fifo_rd_data;
  logic                      push_drop;

  assign beat_fire = score_valid && score_ready_q;

  // NOTE: every signal written here gets a default at the top of the block so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    beat_idx_d  = (beat_idx_q == BEAT_SAT) ? BEAT_SAT : beat_idx_q + 5'd1;

    // Beat 0 always loads; later beats need a strict win so ties keep the
    // lower index. Beats past index 15 cannot be encoded and the frame is
    // malformed anyway, so they are ignored.
    if (beat_idx_q == 5'd0) begin
      best_d     = score_data;
      best_idx_d = 4'd0;
    end else if (beat_idx_q < BEAT_SAT && score_data > best_q) begin
      best_d     = score_data;
      best_idx_d = beat_idx_q[3:0];
    end

    // Beat count including the current (last) beat.
    total_beats = {1'b0, beat_idx_q} + 6'd1;
    malformed   = (total_beats != 6'(N_CLASSES));

    // Confidence is the four magnitude bits just below the sign bit.
    conf = 4'd0;
    if (!malformed && !best_d[SCORE_W-1]) conf = best_d[SCORE_W-2 -: 4];
    cls  = malformed ? MALFORMED_CLASS : best_idx_d;

    fin_word_d = pack_req(frame_id_q, cls, conf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_ready_q <= 1'b0;
      beat_idx_q    <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      frame_id_q    <= '0;
      fin_vld_q     <= 1'b0;
      fin_word_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      score_ready_q <= 1'b1;
      fin_vld_q     <= 1'b0;

      if (beat_fire) begin
        if (score_last) begin
          // Frame complete: stage the word for the queue and start afresh.
          fin_vld_q  <= 1'b1;
          fin_word_q <= fin_word_d;
          frame_id_q <= frame_id_q + 4'd1;
          beat_idx_q <= '0;
          best_q     <= '0;
          best_idx_q <= '0;
        end else begin
          beat_idx_q <= beat_idx_d;
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
        end
      end

      if (push_drop && drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_wr   = fin_vld_q && (!fifo_full || fifo_pop);
  assign push_drop = fin_vld_q && fifo_full && !fifo_pop;

  result_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fin_word_q),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Issue FSM
  //   IDLE pops the head as soon as one is queued and pulses Request_vld.
  //   GAP counts the timer down from GAP_CYCLES-1 and returns to IDLE on the
  //   edge where it reaches 0, so the next pop lands exactly GAP_CYCLES
  //   cycles after the previous one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      request_q     <= '0;
      request_vld_q <= 1'b0;
    end else begin
      request_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            request_q     <= fifo_rd_data;
            request_vld_q <= 1'b1;
            timer_q       <= TMR_W'(GAP_CYCLES - 1);
            state_q       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_q <= TMR_W'(1)) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign score_ready = score_ready_q;
  assign Request     = request_q;
  assign Request_vld = request_vld_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_result_request_packer.sv
// -----------------------------------------------------------------------------
// tb_result_request_packer
//   Directed bench: reset values, single frame latency and packing, ties and
//   negative scores, malformed frame, backlog with one drop and exact pulse
//   spacing, reset during gap and mid-frame, frame id wrap.
// -----------------------------------------------------------------------------
module tb_result_request_packer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] score_data = '0;
  logic               score_valid = 1'b0;
  logic               score_last = 1'b0;
  logic               score_ready;
  logic [11:0]        Request;
  logic               Request_vld;
  logic [2:0]         fifo_level;
  logic [7:0]         drop_count;

  result_request_packer #(
    .N_CLASSES  (10),
    .SCORE_W    (16),
    .GAP_CYCLES (402),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score_data  (score_data),
    .score_valid (score_valid),
    .score_last  (score_last),
    .score_ready (score_ready),
    .Request     (Request),
    .Request_vld (Request_vld),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc++;

  // Every issued request with the cycle it was seen in.
  logic [11:0] pulse_word_q [$];
  int          pulse_cyc_q  [$];

  always @(negedge clk) begin
    if (Request_vld === 1'b1) begin
      pulse_word_q.push_back(Request);
      pulse_cyc_q.push_back(cyc);
    end
  end

  logic signed [15:0] sc [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pw(input int k);
    if (k < pulse_word_q.size()) return pulse_word_q[k];
    return 'x;
  endfunction

  function automatic int pc(input int k);
    if (k < pulse_cyc_q.size()) return pulse_cyc_q[k];
    return -1000000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle reset pulse; outputs are checked right after the reset edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst         = 1'b1;
    score_valid = 1'b0;
    score_last  = 1'b0;
    @(negedge clk);
    check({tag, "_request"}, 32'(Request), 32'h0);
    check({tag, "_vld"},     32'(Request_vld), 32'h0);
    check({tag, "_level"},   32'(fifo_level), 32'h0);
    check({tag, "_drop"},    32'(drop_count), 32'h0);
    check({tag, "_ready"},   32'(score_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    pulse_word_q.delete();
    pulse_cyc_q.delete();
  endtask

  // Drive sc[0..n-1] back-to-back from a negedge; ends at the negedge after
  // the final beat was accepted.
  task automatic send_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      score_valid = 1'b1;
      score_data  = sc[i];
      score_last  = with_last && (i == n - 1);
      @(negedge clk);
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int waited = 0;
    while (pulse_word_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_arrived"}, 32'(pulse_word_q.size() >= n), 32'h1);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) sc[i] = 16'(i * 100);
    sc[7] = 16'sh4000;
  endtask

  task automatic set_const(input logic signed [15:0] v);
    for (int i = 0; i < 16; i++) sc[i] = v;
  endtask

  // Peak of 0x3000 at class cls: confidence bits [14:11] = 4'b0110.
  task automatic set_peak(input int cls);
    for (int i = 0; i < 16; i++) sc[i] = -16'sd100;
    sc[cls] = 16'sh3000;
  endtask

  initial begin
    // ---------------- Reset values ----------------
    repeat (2) @(negedge clk);
    check("rst_request", 32'(Request), 32'h0);
    check("rst_vld",     32'(Request_vld), 32'h0);
    check("rst_level",   32'(fifo_level), 32'h0);
    check("rst_drop",    32'(drop_count), 32'h0);
    check("rst_ready",   32'(score_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(score_ready), 32'h1);

    // ---------------- Single frame, 2-cycle latency ----------------
    set_ramp();
    send_frame(10, 1'b1);
    check("single_vld_t0", 32'(Request_vld), 32'h0);
    tick(1);
    check("single_vld_t1",   32'(Request_vld), 32'h0);
    check("single_level_t1", 32'(fifo_level), 32'h1);
    tick(1);
    check("single_vld_t2",   32'(Request_vld), 32'h1);
    check("single_request",  32'(Request), 32'h078);
    check("single_level_t2", 32'(fifo_level), 32'h0);
    tick(1);
    check("single_vld_t3",   32'(Request_vld), 32'h0);
    check("single_hold",     32'(Request), 32'h078);

    // ---------------- Tie / negative, then frame id 1 ----------------
    do_reset("rst_a");
    set_const(-16'sd5);
    send_frame(10, 1'b1);
    wait_pulses(1, 10, "tie");
    check("tie_request", 32'(pw(0)), 32'h000);
    set_ramp();
    send_frame(10, 1'b1);
    wait_pulses(2, 500, "fid1");
    check("fid1_request", 32'(pw(1)), 32'h178);
    check("fid1_spacing", 32'(pc(1) - pc(0)), 32'd402);

    // ---------------- Malformed frame (last on beat 6) ----------------
    set_ramp();
    send_frame(7, 1'b1);
    wait_pulses(3, 500, "malformed");
    check("malformed_request", 32'(pw(2)), 32'h2F0);
    tick(410);

    // ---------------- Backlog: 6 frames back-to-back ----------------
    for (int k = 0; k < 6; k++) begin
      set_peak(k);
      send_frame(10, 1'b1);
    end
    tick(2);
    check("backlog_drop",  32'(drop_count), 32'h1);
    check("backlog_level", 32'(fifo_level), 32'h4);
    wait_pulses(8, 2500, "backlog");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("backlog_req%0d", k), 32'(pw(3 + k)),
            32'({4'(3 + k), 4'(k), 4'h6}));
    end
    for (int k = 1; k < 5; k++) begin
      check($sformatf("backlog_spacing%0d", k), 32'(pc(3 + k) - pc(2 + k)), 32'd402);
    end
    set_ramp();
    send_frame(10, 1'b1);
    wait_pulses(9, 600, "skip");
    check("skip_request", 32'(pw(8)), 32'h978);

    // ---------------- Reset during GAP and mid-frame ----------------
    set_ramp();
    send_frame(4, 1'b0);
    do_reset("rst_mid");
    set_ramp();
    send_frame(10, 1'b1);
    check("post_rst_vld_t0", 32'(Request_vld), 32'h0);
    tick(1);
    check("post_rst_vld_t1", 32'(Request_vld), 32'h0);
    tick(1);
    check("post_rst_vld_t2",  32'(Request_vld), 32'h1);
    check("post_rst_request", 32'(Request), 32'h078);

    // ---------------- Frame id wrap over 17 paced frames ----------------
    do_reset("rst_wrap");
    for (int i = 0; i < 17; i++) begin
      set_peak(i % 10);
      send_frame(10, 1'b1);
      wait_pulses(i + 1, 600, $sformatf("wrap%0d", i));
      check($sformatf("wrap_req%0d", i), 32'(pw(i)),
            32'({4'(i % 16), 4'(i % 10), 4'h6}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
